// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state encodings and byte-lane constants for the load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILLEGAL = 2'b11} size_e;
  typedef enum logic [2:0] {IDLE, LO, HI, LAST, RESP} state_e;
  localparam int LANES = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = LANES * LANE_W;
  function automatic logic [2*LANES-1:0] lane_mask(size_e size, logic [1:0] off);
    logic [2*LANES-1:0] base;
    base = size == SZ_BYTE ? 8'h01 : size == SZ_HALF ? 8'h03 : 8'h0F;
    return base << off;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane mask, shifted store data and extracted/extended load data.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e                 size,
  input  logic [1:0]            off,
  input  logic                  uns,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [WORD_W-1:0]     lo,
  input  logic [WORD_W-1:0]     hi,
  output logic [2*LANES-1:0]    mask,
  output logic [2*WORD_W-1:0]   wdata_sh,
  output logic [WORD_W-1:0]     rdata
);
  logic [WORD_W-1:0] rd_sh;
  always_comb begin
    mask = lane_mask(size, off);
    wdata_sh = {{WORD_W{1'b0}}, wdata} << {off, 3'b000};
    rd_sh = WORD_W'({hi, lo} >> {off, 3'b000});
    rdata = size == SZ_BYTE ? {{24{~uns & rd_sh[7]}}, rd_sh[7:0]} :
            size == SZ_HALF ? {{16{~uns & rd_sh[15]}}, rd_sh[15:0]} : rd_sh;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a 32-bit synchronous-read memory.
// Define LSU_SPLIT_MISALIGNED_EN to perform word-crossing accesses as two beats instead of faulting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int MEM_SIZE = 8192,
  localparam int AW = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_fault,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_data_en,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);
`ifdef LSU_SPLIT_MISALIGNED_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  state_e      state;
  size_e       size_q, a_size;
  logic        we_q, uns_q, split_q, a_uns, split_now, fault_now;
  logic [1:0]  off_q, a_off;
  logic [31:0] wdata_q, lo_q, a_wdata, lo_in, ld_data;
  logic [7:0]  mask;
  logic [63:0] wdata_sh;
  logic        unused;
  assign unused = ^req_addr[31:AW];
  // While idle the aligner looks at the incoming request so the first beat can launch on accept.
  always_comb begin
    a_size = state == IDLE ? size_e'(req_size) : size_q;
    a_off = state == IDLE ? req_addr[1:0] : off_q;
    a_uns = state == IDLE ? req_unsigned : uns_q;
    a_wdata = state == IDLE ? req_wdata : wdata_q;
    lo_in = state == HI ? mem_rdata : lo_q;
    split_now = |mask[7:4];
    fault_now = req_size == SZ_ILLEGAL || (split_now && !SPLIT_EN);
    req_ready = state == IDLE;
  end
  lsu_lane_align u_align (
    .size     (a_size),
    .off      (a_off),
    .uns      (a_uns),
    .wdata    (a_wdata),
    .lo       (lo_in),
    .hi       (mem_rdata),
    .mask     (mask),
    .wdata_sh (wdata_sh),
    .rdata    (ld_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      mem_we <= 1'b0;
      mem_data_en <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_we <= 1'b0;
      mem_data_en <= '0;
      case (state)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          size_q <= size_e'(req_size);
          uns_q <= req_unsigned;
          off_q <= req_addr[1:0];
          wdata_q <= req_wdata;
          split_q <= split_now;
          if (fault_now) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state <= LO;
            mem_addr <= {req_addr[AW-1:2], 2'b00};
            mem_data_en <= mask[3:0];
            mem_wdata <= wdata_sh[31:0];
            mem_we <= req_we;
          end
        end
        LO: if (!we_q || split_q) begin
          state <= HI;
          if (split_q) begin
            mem_addr <= mem_addr + AW'(4);
            mem_data_en <= mask[7:4];
            mem_wdata <= wdata_sh[63:32];
            mem_we <= we_q;
          end
        end else begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
        end
        HI: begin
          lo_q <= mem_rdata;
          if (split_q && !we_q) state <= LAST;
          else begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= we_q ? '0 : ld_data;
          end
        end
        LAST: begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= ld_data;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store traffic against a byte-array reference model.
module tb_load_store_unit;
  localparam int MEM_SIZE = 8192;
  localparam int AW = 13;
`ifdef LSU_SPLIT_MISALIGNED_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_fault, mem_we;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0] mem_data_en;
  logic [7:0] mem [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];
  int n_checks = 0, n_fail = 0;
  int wcnt = 0;
  logic [31:0] wb_addr [256], wb_en [256], wb_data [256];
  int g_lat, g_beats, g_w0;
  logic [31:0] g_rd;
  logic g_flt;

  load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_data_en(mem_data_en), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= {mem[int'(mem_addr)+3], mem[int'(mem_addr)+2], mem[int'(mem_addr)+1], mem[int'(mem_addr)]};
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_data_en[i]) mem[int'(mem_addr)+i] = mem_wdata[8*i+:8];
  end

  always @(negedge clk)
    if (mem_we) begin
      wb_addr[wcnt % 256] = 32'(mem_addr);
      wb_en[wcnt % 256] = 32'(mem_data_en);
      wb_data[wcnt % 256] = mem_wdata;
      wcnt++;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                       output logic flt, output int beats);
    int nb, a, off;
    bit split;
    logic [31:0] v;
    nb = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
    a = int'(addr[AW-1:0]);
    off = a % 4;
    split = off + nb > 4;
    flt = size == 2'd3 || (split && !SPLIT_EN);
    rd = '0;
    beats = 0;
    v = '0;
    if (flt) lat = 1;
    else if (we) begin
      lat = split ? 3 : 2;
      beats = split ? 2 : 1;
      for (int i = 0; i < nb; i++) ref_mem[(a + i) % MEM_SIZE] = wdata[8*i+:8];
    end else begin
      lat = split ? 4 : 3;
      for (int i = 0; i < nb; i++) v[8*i+:8] = ref_mem[(a + i) % MEM_SIZE];
      if (!uns && v[8*nb-1])
        for (int i = nb; i < 4; i++) v[8*i+:8] = 8'hFF;
      rd = v;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    g_w0 = wcnt;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    g_lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        g_lat = i;
        break;
      end
    end
    g_rd = resp_rdata;
    g_flt = resp_fault;
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'd0);
    g_beats = wcnt - g_w0;
  endtask

  task automatic run(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int e_lat, e_beats;
    logic [31:0] e_rd;
    logic e_flt;
    model(we, size, uns, addr, wdata, e_lat, e_rd, e_flt, e_beats);
    do_req(we, size, uns, addr, wdata);
    check({tag, "_lat"}, 32'(g_lat), 32'(e_lat));
    check({tag, "_rdata"}, g_rd, e_rd);
    check({tag, "_fault"}, 32'(g_flt), 32'(e_flt));
    check({tag, "_beats"}, 32'(g_beats), 32'(e_beats));
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] ad;
    int r, seen;
    for (int i = 0; i < MEM_SIZE; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_fault", 32'(resp_fault), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_en", 32'(mem_data_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, "st_word");
    check("st_word_addr", wb_addr[g_w0 % 256], 32'h100);
    check("st_word_en", wb_en[g_w0 % 256], 32'hF);
    run(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, "ld_word");
    check("ld_word_val", g_rd, 32'hDEADBEEF);

    run(1'b1, 2'd0, 1'b0, 32'h103, 32'h80, "st_byte");
    check("st_byte_en", wb_en[g_w0 % 256], 32'h8);
    check("st_byte_lane", 32'(wb_data[g_w0 % 256][31:24]), 32'h80);
    run(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, "ld_sbyte");
    check("ld_sbyte_val", g_rd, 32'hFFFFFF80);
    run(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, "ld_ubyte");
    check("ld_ubyte_val", g_rd, 32'h00000080);

    run(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, "st_half");
    check("st_half_en", wb_en[g_w0 % 256], 32'hC);
    check("st_half_data", wb_data[g_w0 % 256], 32'h12340000);
    run(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, "ld_uhalf");
    check("ld_uhalf_val", g_rd, 32'h00001234);

    run(1'b1, 2'd2, 1'b0, 32'h1FE, 32'hAABBCCDD, "st_split");
`ifdef LSU_SPLIT_MISALIGNED_EN
    check("st_split_a0", wb_addr[g_w0 % 256], 32'h1FC);
    check("st_split_e0", wb_en[g_w0 % 256], 32'hC);
    check("st_split_d0", wb_data[g_w0 % 256], 32'hCCDD0000);
    check("st_split_a1", wb_addr[(g_w0 + 1) % 256], 32'h200);
    check("st_split_e1", wb_en[(g_w0 + 1) % 256], 32'h3);
    check("st_split_d1", wb_data[(g_w0 + 1) % 256], 32'h0000AABB);
    run(1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0, "ld_split");
    check("ld_split_val", g_rd, 32'hAABBCCDD);
    run(1'b1, 2'd1, 1'b0, 32'h1FFF, 32'h5A6B, "st_wrap");
    check("st_wrap_a1", wb_addr[(g_w0 + 1) % 256], 32'h0);
    check("st_wrap_e1", wb_en[(g_w0 + 1) % 256], 32'h1);
`else
    check("st_split_flt", 32'(g_flt), 32'd1);
    run(1'b1, 2'd1, 1'b0, 32'h1FFF, 32'h5A6B, "st_wrap");
    check("st_wrap_flt", 32'(g_flt), 32'd1);
`endif
    run(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, "illegal");
    check("illegal_flt", 32'(g_flt), 32'd1);

`ifdef LSU_SPLIT_MISALIGNED_EN
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h1FE; req_wdata = 32'h11223344;
`else
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h100; req_wdata = 32'h0;
`endif
    req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("midrst_noresp", 32'(seen), 32'd0);
`ifdef LSU_SPLIT_MISALIGNED_EN
    for (int i = 0; i < 4; i++) ref_mem[32'h1FE + i] = req_wdata[8*i+:8];
`endif

    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 7));
      sz = r < 2 ? 2'd0 : r < 4 ? 2'd1 : r < 7 ? 2'd2 : 2'd3;
      ad = $urandom_range(0, 3) == 0 ? 32'(MEM_SIZE - 8 + int'($urandom_range(0, 7)))
                                     : 32'($urandom_range(0, 40));
      ad = ad | ($urandom << AW);
      run(1'($urandom), sz, 1'($urandom), ad, $urandom, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 8192, bytes of attached memory; AW = $clog2(MEM_SIZE).
REQ-002 SHALL have clk  input  1  sole clock, all logic on posedge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have req_valid  input  1  request present; req_ready  output  1  unit accepts when high.
REQ-005 SHALL have req_we  input  1  1=store 0=load; req_size  input  2  00 byte, 01 half, 10 word, 11 illegal; req_unsigned  input  1  zero- vs sign-extend loads.
REQ-006 SHALL have req_addr  input  32  byte address, bits above AW ignored; req_wdata  input  32  store data, right-justified.
REQ-007 SHALL have resp_valid  output  1  one-cycle completion pulse; resp_rdata  output  32  extended load data; resp_fault  output  1  access rejected.
REQ-008 SHALL have mem_addr  output  AW; mem_wdata  output  32; mem_data_en  output  4  byte lanes; mem_we  output  1; mem_rdata  input  32, valid one cycle after mem_addr is driven.

Function
REQ-009 SHALL accept a request when req_valid && req_ready (cycle N), registering all req_* fields; req_ready high only in IDLE.
REQ-010 SHALL use states IDLE, LO, HI, LAST, RESP; IDLE->LO on accept; LO->HI if load or split, else RESP; HI->LAST if split load, else RESP; LAST->RESP; RESP->IDLE.
REQ-011 SHALL compute off=addr[1:0], nbytes=1/2/4, 8-bit mask=((1<<nbytes)-1)<<off; split = mask[7:4]!=0.
REQ-012 SHALL in LO drive mem_addr=addr&~3, mem_data_en=mask[3:0], mem_wdata=(wdata<<8*off)[31:0], mem_we=req_we.
REQ-013 SHALL in HI capture mem_rdata as low word (loads) and, if split, drive mem_addr=((addr&~3)+4) mod MEM_SIZE, mem_data_en=mask[7:4], mem_wdata=(wdata<<8*off)[63:32], mem_we=req_we.
REQ-014 SHALL in LAST capture mem_rdata as high word; mem_we=0 in IDLE, LAST, RESP and in HI when not split.
REQ-015 SHALL form load result as ({hi,lo}>>8*off) truncated to nbytes, zero-extended if req_unsigned else sign-extended, registered into resp_rdata at RESP entry.
REQ-016 SHALL assert resp_valid for exactly the RESP cycle; latencies from N: aligned store N+2, aligned load N+3, split store N+3, split load N+4, fault N+1.
REQ-017 SHALL treat req_size=11 as fault: IDLE->RESP, resp_fault=1, resp_rdata=0, no mem_we.
REQ-018 SHALL hold resp_rdata and resp_fault until the next RESP; resp_rdata=0 for stores.

Reset
REQ-019 SHALL on rst set state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, mem_data_en=0, mem_addr=0, mem_wdata=0.
REQ-020 SHALL on rst mid-operation abandon the access with no resp_valid; an already-written LO beat of a split store is not undone.

Configuration
REQ-021 SHALL with LSU_SPLIT_MISALIGNED_EN defined perform split accesses as two beats per REQ-013/014.
REQ-022 SHALL without LSU_SPLIT_MISALIGNED_EN treat any split access as fault per REQ-017 (RESP at N+1, no memory access); non-split behaviour unchanged.

Structure
REQ-023 SHALL place size encoding enum, FSM state enum and byte-lane width constants in package lsu_pkg.
REQ-024 SHALL use one combinational sub-module lsu_lane_align computing mask, shifted write data and extracted/extended load data.

Verification
REQ-025 Store word 0xDEADBEEF @0x100 -> one beat addr 0x100, en 1111, resp N+2; load word @0x100 -> resp_rdata 0xDEADBEEF at N+3.
REQ-026 Store byte 0x80 @0x103 -> en 1000, mem_wdata[31:24]=0x80; signed byte load -> 0xFFFFFF80, unsigned -> 0x00000080.
REQ-027 Store half 0x1234 @0x102 -> en 1100, mem_wdata 0x12340000; unsigned half load -> 0x00001234.
REQ-028 With macro, store word 0xAABBCCDD @0x1FE -> beat1 addr 0x1FC en 1100 wdata 0xCCDD0000, beat2 addr 0x200 en 0011 wdata 0x0000AABB; load -> 0xAABBCCDD at N+4; without macro -> resp_fault=1 at N+1, mem_we never high.
REQ-029 With macro, store half @0x1FFF (MEM_SIZE 8192) -> beat2 addr 0x0000 en 0001 (wrap).
REQ-030 rst during HI of split store -> next cycle mem_we=0, IDLE, no resp_valid; req_size=11 -> resp_fault=1 at N+1.
